// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_receiver
// Purpose  : Oversamples an external SPI link in the pixel_clk domain,
//            deserialises MSB-first RGB565 pixels into the back half of a
//            double-buffered framebuffer and hands finished frames to the
//            display scanner through a swap request/acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_receiver #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 32,
  parameter int ADDR_BITS    = 11,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [15:0]          wr_data,
  output logic                 wr_en,
  output logic                 wr_buffer,
  output logic                 rd_buffer,
  output logic                 frame_done,
  output logic                 swap_req,
  input  logic                 swap_ack,
  output logic                 overrun
);

  localparam int                   PIXELS     = WIDTH * HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_PIXEL = ADDR_BITS'(PIXELS - 1);
  localparam int                   IDLE_BITS  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_BITS-1:0] IDLE_LIMIT = IDLE_BITS'(IDLE_TIMEOUT);

  typedef enum logic [0:0] {
    RECEIVING = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  // Synchroniser chains; the third spi_clk stage only serves edge detection.
  logic [2:0]           sclk_sync;
  logic [1:0]           mosi_sync;
  logic                 rise;
  logic                 timeout;

  logic [IDLE_BITS-1:0] idle_cnt;
  logic [3:0]           bit_cnt;
  logic [15:0]          shift;
  logic                 word_valid;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] pixel_cnt, pix_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic [15:0]          data_next;
  logic                 wr_en_next, done_next, swap_req_next, rd_next, overrun_next;

  assign rise      = sclk_sync[1] & ~sclk_sync[2];
  // Once saturated the timeout stays asserted until the link toggles again.
  assign timeout   = (idle_cnt == IDLE_LIMIT) && !rise;
  // The write half is always the opposite of the displayed half.
  assign wr_buffer = ~rd_buffer;

  // Bring the asynchronous SPI pins into the pixel_clk domain.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  // Count cycles since the last spi_clk rise, saturating at the limit.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (rise) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LIMIT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Shift in one bit per rise; flag a complete word for one cycle.
  // The shift register itself then holds the finished word.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shift      <= 16'h0000;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (timeout) begin
        bit_cnt <= 4'd0;
      end else if (rise) begin
        shift      <= {shift[14:0], mosi_sync[1]};
        bit_cnt    <= bit_cnt + 4'd1;
        word_valid <= (bit_cnt == 4'd15);
      end
    end
  end

  // Frame state register and all registered outputs.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state      <= RECEIVING;
      pixel_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'h0000;
      frame_done <= 1'b0;
      swap_req   <= 1'b0;
      rd_buffer  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      pixel_cnt  <= pix_next;
      wr_en      <= wr_en_next;
      wr_addr    <= addr_next;
      wr_data    <= data_next;
      frame_done <= done_next;
      swap_req   <= swap_req_next;
      rd_buffer  <= rd_next;
      overrun    <= overrun_next;
    end
  end

  // Next-state logic: write words, close frames, handle the swap handshake.
  always_comb begin
    state_next    = state;
    pix_next      = pixel_cnt;
    wr_en_next    = 1'b0;
    addr_next     = wr_addr;
    data_next     = wr_data;
    done_next     = 1'b0;
    swap_req_next = swap_req;
    rd_next       = rd_buffer;
    overrun_next  = overrun;

    case (state)
      RECEIVING: begin
        if (word_valid) begin
          wr_en_next = 1'b1;
          addr_next  = pixel_cnt;
          data_next  = shift;
          if (pixel_cnt == LAST_PIXEL) begin
            pix_next      = '0;
            done_next     = 1'b1;
            swap_req_next = 1'b1;
            state_next    = WAIT_SWAP;
          end else begin
            pix_next = pixel_cnt + 1'b1;
          end
        end else if (timeout) begin
          // Abandon a stalled partial frame.
          pix_next = '0;
        end
      end

      WAIT_SWAP: begin
        if (swap_ack) begin
          rd_next       = ~rd_buffer;
          swap_req_next = 1'b0;
          state_next    = RECEIVING;
          // A word landing on the swap cycle opens the new back buffer.
          if (word_valid) begin
            wr_en_next = 1'b1;
            addr_next  = '0;
            data_next  = shift;
            pix_next   = ADDR_BITS'(1);
          end
        end else if (word_valid) begin
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = RECEIVING;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_receiver
// Purpose  : Scoreboard bench for spi_frame_receiver on a reduced 16x8 panel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_receiver;

  localparam int TB_W  = 16;
  localparam int TB_H  = 8;
  localparam int TB_AB = 7;
  localparam int PIX   = TB_W * TB_H;

  logic             pixel_clk = 1'b0;
  logic             reset     = 1'b1;
  logic             spi_clk   = 1'b0;
  logic             spi_mosi  = 1'b0;
  logic             swap_ack  = 1'b0;
  logic [TB_AB-1:0] wr_addr;
  logic [15:0]      wr_data;
  logic             wr_en, wr_buffer, rd_buffer, frame_done, swap_req, overrun;

  typedef struct packed {
    logic [TB_AB-1:0] addr;
    logic [15:0]      data;
    logic             wbuf;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  spi_frame_receiver #(
    .WIDTH(TB_W), .HEIGHT(TB_H), .ADDR_BITS(TB_AB), .IDLE_TIMEOUT(1024)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .wr_buffer (wr_buffer),
    .rd_buffer (rd_buffer),
    .frame_done(frame_done),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .overrun   (overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Watchdog: a hang is reported and stops the run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge pixel_clk) begin
    if (!reset) begin
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h buf=%b done=%b, required no write",
                   wr_addr, wr_data, wr_buffer, frame_done);
        end else begin
          mon_e = exp_q.pop_front();
          if ({wr_addr, wr_data, wr_buffer, frame_done} !== mon_e) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h buf=%b done=%b, required addr=%h data=%h buf=%b done=%b",
                     wr_addr, wr_data, wr_buffer, frame_done,
                     mon_e.addr, mon_e.data, mon_e.wbuf, mon_e.done);
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: got 1 without wr_en, required 0");
      end
    end
  end

  task automatic push_exp(input logic [TB_AB-1:0] a, input logic [15:0] d,
                          input logic b, input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.wbuf = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    swap_ack = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge pixel_clk);
    reset = 1'b0;
    @(negedge pixel_clk);
  endtask

  // One SPI bit: 3 cycles low then 3 high; optionally pulse swap_ack in the
  // cycle the completed word reaches the frame logic.
  task automatic send_bit(input logic b, input bit ack);
    spi_mosi = b;
    spi_clk  = 1'b0;
    repeat (3) @(negedge pixel_clk);
    spi_clk = 1'b1;
    repeat (3) @(negedge pixel_clk);
    if (ack) begin
      swap_ack = 1'b1;
      @(negedge pixel_clk);
      swap_ack = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] d, input bit ack_last);
    for (int i = 15; i >= 0; i--) send_bit(d[i], (i == 0) && ack_last);
  endtask

  task automatic send_frame(input logic b);
    for (int i = 0; i < PIX; i++) begin
      push_exp(TB_AB'(i), 16'(i), b, (i == PIX - 1));
      send_word(16'(i), 1'b0);
    end
  endtask

  task automatic pulse_ack();
    swap_ack = 1'b1;
    @(negedge pixel_clk);
    swap_ack = 1'b0;
    @(negedge pixel_clk);
  endtask

  task automatic test_reset();
    do_reset();
    push_exp(0, 16'h1357, 1'b1, 1'b0);
    send_word(16'h1357, 1'b0);
    push_exp(1, 16'h2468, 1'b1, 1'b0);
    send_word(16'h2468, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    checks++; if (wr_addr !== '0)      begin errors++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
    checks++; if (wr_data !== 16'h0)   begin errors++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
    checks++; if (wr_buffer !== 1'b1)  begin errors++; $display("FAIL reset_wr_buffer: got %b required 1", wr_buffer); end
    checks++; if (rd_buffer !== 1'b0)  begin errors++; $display("FAIL reset_rd_buffer: got %b required 0", rd_buffer); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    checks++; if (swap_req !== 1'b0)   begin errors++; $display("FAIL reset_swap_req: got %b required 0", swap_req); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    exp_q.delete();
    spi_clk = 1'b0;
    repeat (3) @(negedge pixel_clk);
    reset = 1'b0;
    @(negedge pixel_clk);
    push_exp(0, 16'hC0DE, 1'b1, 1'b0);
    send_word(16'hC0DE, 1'b0);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_single_word();
    logic [15:0] d;
    d = 16'hF800;
    do_reset();
    push_exp(0, d, 1'b1, 1'b0);
    for (int i = 15; i >= 1; i--) send_bit(d[i], 1'b0);
    spi_mosi = d[0];
    spi_clk  = 1'b0;
    repeat (3) @(negedge pixel_clk);
    spi_clk = 1'b1;
    @(posedge pixel_clk);               // first edge sampling spi_clk high
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL latency_early: wr_en got %b required 0 two cycles after sample", wr_en); end
    @(posedge pixel_clk);
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL latency: wr_en got %b required 1 three cycles after sample", wr_en); end
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_full_frame();
    do_reset();
    send_frame(1'b1);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame_drain: got %0d pending writes required 0", exp_q.size()); end
    checks++; if (swap_req !== 1'b1)  begin errors++; $display("FAIL frame_swap_req: got %b required 1", swap_req); end
    checks++; if (rd_buffer !== 1'b0) begin errors++; $display("FAIL frame_rd_before: got %b required 0", rd_buffer); end
    pulse_ack();
    checks++; if (rd_buffer !== 1'b1) begin errors++; $display("FAIL swap_rd_buffer: got %b required 1", rd_buffer); end
    checks++; if (wr_buffer !== 1'b0) begin errors++; $display("FAIL swap_wr_buffer: got %b required 0", wr_buffer); end
    checks++; if (swap_req !== 1'b0)  begin errors++; $display("FAIL swap_req_clear: got %b required 0", swap_req); end
    pulse_ack();
    checks++; if (rd_buffer !== 1'b1) begin errors++; $display("FAIL stray_ack: rd_buffer got %b required 1", rd_buffer); end
    push_exp(0, 16'hABCD, 1'b0, 1'b0);
    send_word(16'hABCD, 1'b0);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL after_swap_drain: got %0d pending writes required 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(1'b1);
    send_word(16'h1111, 1'b0);          // dropped: no expectation pushed
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_drain: got %0d pending writes required 0", exp_q.size()); end
    checks++; if (overrun !== 1'b1)  begin errors++; $display("FAIL overrun_set: got %b required 1", overrun); end
    checks++; if (swap_req !== 1'b1) begin errors++; $display("FAIL overrun_swap_req: got %b required 1", swap_req); end
    pulse_ack();
    push_exp(0, 16'h2222, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_after_drain: got %0d pending writes required 0", exp_q.size()); end
    checks++; if (overrun !== 1'b1)  begin errors++; $display("FAIL overrun_sticky: got %b required 1", overrun); end
  endtask

  task automatic test_idle_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    spi_clk = 1'b0;
    repeat (1100) @(negedge pixel_clk);
    push_exp(0, 16'h1234, 1'b1, 1'b0);
    send_word(16'h1234, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      push_exp(TB_AB'(i), 16'(16'h0100 + i), 1'b1, 1'b0);
      send_word(16'(16'h0100 + i), 1'b0);
    end
    repeat (1100) @(negedge pixel_clk);
    push_exp(0, 16'h4321, 1'b1, 1'b0);
    send_word(16'h4321, 1'b0);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL idle_drain: got %0d pending writes required 0", exp_q.size()); end
    checks++; if (swap_req !== 1'b0) begin errors++; $display("FAIL idle_swap_req: got %b required 0", swap_req); end
  endtask

  task automatic test_swap_collision();
    do_reset();
    send_frame(1'b1);
    push_exp(0, 16'h5A5A, 1'b0, 1'b0);
    send_word(16'h5A5A, 1'b1);
    push_exp(1, 16'h0F0F, 1'b0, 1'b0);
    send_word(16'h0F0F, 1'b0);
    repeat (8) @(negedge pixel_clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL collide_drain: got %0d pending writes required 0", exp_q.size()); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL collide_overrun: got %b required 0", overrun); end
    checks++; if (rd_buffer !== 1'b1) begin errors++; $display("FAIL collide_rd_buffer: got %b required 1", rd_buffer); end
    checks++; if (swap_req !== 1'b0)  begin errors++; $display("FAIL collide_swap_req: got %b required 0", swap_req); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_overrun();
    test_idle_timeout();
    test_swap_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Upstream stage of the HUB75 controller.
- Oversamples the external SPI link (spi_clk, spi_mosi) in the pixel_clk domain and deserialises 16-bit RGB565 pixels, MSB first.
- Writes each pixel into the back half of the double-buffered 64x32 framebuffer.
- Hands completed frames to the display scanner through a swap handshake.

Parameters:
- WIDTH, 64, panel columns
- HEIGHT, 32, panel rows
- ADDR_BITS, 11, framebuffer word address width; must equal log2(WIDTH*HEIGHT)
- IDLE_TIMEOUT, 1024, pixel_clk cycles without an spi_clk rising edge before the receiver resynchronises

Ports:
- pixel_clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high
- spi_clk  in  1  external SPI clock, asynchronous to pixel_clk; data is captured on its rising edge
- spi_mosi  in  1  external SPI data, asynchronous
- wr_addr  out  ADDR_BITS  framebuffer word address (row*WIDTH+col)
- wr_data  out  16  RGB565 pixel
- wr_en  out  1  one-cycle framebuffer write strobe
- wr_buffer  out  1  framebuffer half being written (back buffer)
- rd_buffer  out  1  framebuffer half the display reads (front buffer)
- frame_done  out  1  one-cycle pulse on the last pixel of a frame
- swap_req  out  1  level; a complete frame is waiting for a swap
- swap_ack  in  1  single-cycle pulse from the scanner at a display frame boundary
- overrun  out  1  sticky; a word was dropped

Behaviour:
Reset values:
- All outputs are 0, except wr_buffer = 1.
- Bit counter, pixel counter and shift register are 0.
- Idle counter is 0.
- State is RECEIVING.
- Reset takes effect immediately and mid-word; no partial write is emitted.

Input sampling and timing:
- spi_clk and spi_mosi each pass through two flip-flops; a third stage on spi_clk detects edges.
- rise = sync2 & ~sync3. spi_mosi is taken from its own sync2 on rise.
- Input constraint: spi_clk high and low each last at least 3 pixel_clk periods; spi_mosi is stable from 1 cycle before to 1 cycle after the spi_clk rising edge.
- Latency: wr_en rises 3 pixel_clk cycles after the first pixel_clk edge that samples spi_clk high for bit 15 (the last bit).
- wr_addr and wr_data are valid in the same cycle as wr_en and hold until the next write.

Deserialiser:
- A 4-bit counter counts 0..15.
- On the 16th bit: wr_data = {shift[14:0], bit}; counter returns to 0.

State machine:
- RECEIVING, word complete:
  - Assert wr_en for one cycle with wr_addr = pixel_cnt, then increment pixel_cnt.
  - When pixel_cnt = WIDTH*HEIGHT-1: wrap pixel_cnt to 0, pulse frame_done in the same cycle as the final wr_en, set swap_req and go to WAIT_SWAP.
- WAIT_SWAP, bit reception continues:
  - A completed word is dropped: no wr_en, pixel_cnt unchanged, overrun set to 1.
- WAIT_SWAP, swap_ack:
  - rd_buffer toggles and wr_buffer toggles; wr_buffer == ~rd_buffer always holds.
  - swap_req clears; state returns to RECEIVING.
- swap_ack and word completion in the same cycle in WAIT_SWAP:
  - The swap wins and the word is not dropped.
  - It is written in that cycle to address 0 with the new wr_buffer value; pixel_cnt becomes 1; overrun is not set.
- swap_ack when swap_req = 0: ignored.

Idle timeout:
- The idle counter clears on every rise and saturates at IDLE_TIMEOUT.
- On reaching IDLE_TIMEOUT: bit counter clears.
- In RECEIVING, pixel_cnt also clears, discarding the partial frame; no frame_done, no swap.
- In WAIT_SWAP, pixel_cnt is already 0 and the pending swap is kept.

overrun clears only on reset.

Test Plan:
1. Assert reset mid-run -> all outputs 0, wr_buffer = 1, rd_buffer = 0; after release the first word lands at wr_addr 0.
2. Shift 0xF800 MSB first after reset -> exactly one wr_en, wr_addr = 0, wr_data = 0xF800, wr_buffer = 1, 3 cycles after the last spi_clk rise.
3. Send 2048 words with data = index:
   - Expect 2048 strobes; the last has wr_addr 0x7FF and wr_data 0x07FF.
   - frame_done pulses with that strobe; swap_req = 1.
   - Pulse swap_ack -> rd_buffer = 1, wr_buffer = 0, swap_req = 0.
   - Next word 0xABCD -> written at addr 0.
4. Complete a frame, withhold swap_ack, send 0x1111 -> no wr_en, overrun = 1, swap_req still 1. Then ack and send 0x2222 -> written at addr 0.
5. Send 5 bits, idle 1100 cycles, send 0x1234 -> wr_addr 0, wr_data 0x1234. Repeat with 10 words sent first -> next word at addr 0, no frame_done.
6. Complete a frame and align the swap_ack pulse with the completion cycle of word 0x5A5A -> buffers swap, 0x5A5A written at addr 0 with wr_buffer = 0, overrun stays 0.
